// File: rtl/bin2ascii_dec6.sv
// rtl/bin2ascii_dec6.sv - iterative binary to six-digit ASCII decimal converter (double-dabble)
// Optional feature macro: BIN2ASCII_SIGNED_EN (two's complement input, sign shown in char5).
module bin2ascii_dec6 #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       char0,
  output logic [7:0]       char1,
  output logic [7:0]       char2,
  output logic [7:0]       char3,
  output logic [7:0]       char4,
  output logic [7:0]       char5
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef BIN2ASCII_SIGNED_EN
  // char5 carries the sign, so only five digits are available.
  localparam logic [31:0] LIMIT   = 32'd99999;
  localparam int          DIG_TOP = 4;
`else
  localparam logic [31:0] LIMIT   = 32'd999999;
  localparam int          DIG_TOP = 5;
`endif

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_E     = 8'd69;
  localparam logic [7:0] ASCII_MINUS = 8'd45;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FMT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [23:0]       bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              blank_q, blank_d;
  logic              big_q, big_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [5:0][7:0]   chars_q, chars_d;
`ifdef BIN2ASCII_SIGNED_EN
  logic              neg_q, neg_d;
  logic              neg_in;
`endif

  logic [WIDTH-1:0]  mag;
  logic              too_big;
  logic [23:0]       bcd_adj;
  logic [5:0][7:0]   fmt_chars;
  logic              fmt_lead;

  // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
  function automatic logic [23:0] dabble_adj(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Magnitude of the incoming value and its range check, evaluated at capture time.
  always_comb begin
`ifdef BIN2ASCII_SIGNED_EN
    neg_in = value[WIDTH-1];
    // The most negative value maps to 2**(WIDTH-1) read as unsigned, so no wrap.
    mag    = neg_in ? (~value + WIDTH'(1)) : value;
`else
    mag    = value;
`endif
    too_big = (32'(mag) > LIMIT);
  end

  assign bcd_adj = dabble_adj(bcd_q);

  // Digit formatting: ASCII digits, optional leading-zero blanking, sign and overflow override.
  always_comb begin
    fmt_chars = '0;
    fmt_lead  = blank_q;
    for (int i = 5; i >= 0; i--) begin
      if (i <= DIG_TOP) begin
        if (fmt_lead && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
          fmt_chars[i] = 8'h00;
        end else begin
          fmt_chars[i] = ASCII_ZERO + {4'd0, bcd_q[4*i +: 4]};
          fmt_lead     = 1'b0;
        end
      end
    end
`ifdef BIN2ASCII_SIGNED_EN
    fmt_chars[5] = neg_q ? ASCII_MINUS : 8'h00;
`endif
    if (big_q) begin
      fmt_chars = {6{ASCII_E}};
    end
  end

  // Next-state and datapath control for IDLE -> SHIFT -> FMT.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    big_d   = big_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    chars_d = chars_q;
`ifdef BIN2ASCII_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = mag;
          big_d   = too_big;
          blank_d = blank_lz;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef BIN2ASCII_SIGNED_EN
          neg_d   = neg_in;
`endif
        end
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[22:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FMT;
        end
      end
      S_FMT: begin
        chars_d = fmt_chars;
        ovf_d   = big_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      big_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      chars_q <= '0;
`ifdef BIN2ASCII_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      big_q   <= big_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      chars_q <= chars_d;
`ifdef BIN2ASCII_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign char0 = chars_q[0];
  assign char1 = chars_q[1];
  assign char2 = chars_q[2];
  assign char3 = chars_q[3];
  assign char4 = chars_q[4];
  assign char5 = chars_q[5];

endmodule
